rv32i_prog_loader: RTL and testbench

//  Boot-time program writer for the rv32i core's instruction memory (MEM), word-addressed.

---
 rtl/rv32i_pkg.sv | 21 ++
 rtl/rv32i_prog_loader_if.sv | 28 ++
 rtl/rv32i_loader_word_asm.sv | 52 +++++
 rtl/rv32i_prog_loader.sv | 132 +++++++++++++
 tb/tb_rv32i_prog_loader.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i boot loader slice: datapath width,
// default frame marker and the loader state encoding.
package rv32i_pkg;

    localparam int         XLEN          = 32;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_LO,
        ST_ADDR_HI,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/rv32i_prog_loader_if.sv
// Byte-stream input, instruction-memory write port and core status of the loader.
// master = host/system side, slave = the loader itself.
interface rv32i_prog_loader_if #(
    parameter int ADDR_W = 10
);
    import rv32i_pkg::*;

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic              core_hold;
    logic              done;
    logic              err;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, err
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, err
    );

endinterface

// File: rtl/rv32i_loader_word_asm.sv
// 8->32 little-endian word assembler. word presents the register contents with
// the byte being loaded this cycle already merged in, so the completed word is
// available on the same edge that accepts its last byte.
module rv32i_loader_word_asm
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            load,
    input  logic [7:0]      byte_in,
    output logic [XLEN-1:0] word,
    output logic            word_full
);

    logic [1:0] idx_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg <= 2'd0;
        end else if (clr) begin
            idx_reg <= 2'd0;
        end else if (load) begin
            idx_reg <= idx_reg + 2'd1;
        end
    end

    // Asserted while the next loaded byte completes the word.
    assign word_full = (idx_reg == 2'd3);

    generate
        for (genvar gi = 0; gi < XLEN / 8; gi++) begin : g_lane
            logic [7:0] lane_reg;
            logic       lane_hit;

            assign lane_hit = load && (idx_reg == 2'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_reg <= 8'd0;
                end else if (clr) begin
                    lane_reg <= 8'd0;
                end else if (lane_hit) begin
                    lane_reg <= byte_in;
                end
            end

            assign word[8*gi +: 8] = lane_hit ? byte_in : lane_reg;
        end
    endgenerate

endmodule

// File: rtl/rv32i_prog_loader.sv
// Boot-time program writer: parses framed bytes, writes words into instruction
// memory and keeps the core held until the frame checksum verifies.
module rv32i_prog_loader
    import rv32i_pkg::*;
#(
    parameter int         ADDR_W    = 10,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    rv32i_prog_loader_if.slave  bus
);

    loader_state_t     state_reg;
    logic              in_ready_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [XLEN-1:0]   mem_wdata_reg;
    logic              core_hold_reg;
    logic              done_reg;
    logic              err_reg;
    logic [15:0]       words_left_reg;
    logic [7:0]        csum_reg;
    logic [7:0]        lo_reg;

    logic              accept;
    logic              is_sync;
    logic              frame_start;
    logic              asm_load;
    logic              word_full;
    logic [XLEN-1:0]   asm_word;

    assign accept   = bus.in_valid && in_ready_reg;
    assign is_sync  = (bus.in_data == SYNC_BYTE);
    assign asm_load = accept && (state_reg == ST_DATA);
    assign frame_start = accept && is_sync &&
                         (state_reg == ST_IDLE || state_reg == ST_DONE || state_reg == ST_ERR);

    rv32i_loader_word_asm u_word_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (frame_start),
        .load      (asm_load),
        .byte_in   (bus.in_data),
        .word      (asm_word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            in_ready_reg   <= 1'b1;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            core_hold_reg  <= 1'b1;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            words_left_reg <= 16'd0;
            csum_reg       <= 8'd0;
            lo_reg         <= 8'd0;
        end else begin
            mem_we_reg <= 1'b0;
            if (frame_start) begin
                state_reg     <= ST_ADDR_LO;
                csum_reg      <= 8'd0;
                core_hold_reg <= 1'b1;
                done_reg      <= 1'b0;
                err_reg       <= 1'b0;
            end
            case (state_reg)
                ST_ADDR_LO, ST_CNT_LO: begin
                    if (accept) begin
                        lo_reg    <= bus.in_data;
                        state_reg <= (state_reg == ST_ADDR_LO) ? ST_ADDR_HI : ST_CNT_HI;
                    end
                end
                ST_ADDR_HI: begin
                    if (accept) begin
                        mem_addr_reg <= ADDR_W'({bus.in_data, lo_reg});
                        state_reg    <= ST_CNT_LO;
                    end
                end
                ST_CNT_HI: begin
                    if (accept) begin
                        words_left_reg <= {bus.in_data, lo_reg};
                        state_reg      <= ({bus.in_data, lo_reg} == 16'd0) ? ST_CHECK : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        csum_reg <= csum_reg ^ bus.in_data;
                        if (word_full) begin
                            mem_wdata_reg <= asm_word;
                            mem_we_reg    <= 1'b1;
                            in_ready_reg  <= 1'b0;
                            state_reg     <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    in_ready_reg   <= 1'b1;
                    mem_addr_reg   <= mem_addr_reg + 1'b1;
                    words_left_reg <= words_left_reg - 16'd1;
                    state_reg      <= (words_left_reg == 16'd1) ? ST_CHECK : ST_DATA;
                end
                ST_CHECK: begin
                    if (accept) begin
                        if (bus.in_data == csum_reg) begin
                            state_reg     <= ST_DONE;
                            core_hold_reg <= 1'b0;
                            done_reg      <= 1'b1;
                        end else begin
                            state_reg <= ST_ERR;
                            err_reg   <= 1'b1;
                        end
                    end
                end
                default: ;  // IDLE/DONE/ERR only react to SYNC, handled above
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.core_hold = core_hold_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;

endmodule

// File: tb/tb_rv32i_prog_loader.sv
// Scoreboard bench for rv32i_prog_loader: expected memory writes are queued as
// frames are sent; a negedge monitor pops and compares every mem_we strobe.
module tb_rv32i_prog_loader;
    import rv32i_pkg::*;

    localparam int ADDR_W = 10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    wr_t  exp_q[$];
    int   we_cyc[$];
    logic [7:0] frm[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rv32i_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    rv32i_prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: got %b expected 1", bus.in_ready);
                bus.in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] q[$]);
        foreach (q[i]) send(q[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic h);
        check({tag, "_done"}, 32'(bus.done), 32'(d));
        check({tag, "_err"}, 32'(bus.err), 32'(e));
        check({tag, "_core_hold"}, 32'(bus.core_hold), 32'(h));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check_status(tag, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: in_ready must be low exactly in WRITE cycles; each strobe is scored.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (bus.in_ready !== !bus.mem_we) begin
                errors++;
                $display("FAIL ready_vs_write: in_ready %b mem_we %b", bus.in_ready, bus.mem_we);
            end
            if (bus.mem_we === 1'b1) begin
                wr_t e;
                we_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got [%h]=%h expected no write",
                             bus.mem_addr, bus.mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
                        errors++;
                        $display("FAIL mem_write: got [%h]=%h expected [%h]=%h",
                                 bus.mem_addr, bus.mem_wdata, e.addr, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        idle(3);
        check_reset_values("reset");
        rst = 1'b0;

        // Noise before SYNC is discarded, then a good two-word frame.
        // Checksum is the XOR of the eight data bytes = 0x90.
        frm = '{8'h00, 8'hFF, 8'h5A};
        send_seq(frm);
        check_status("noise", 1'b0, 1'b0, 1'b1);
        we_cyc.delete();
        push(10'h000, 32'h00208300);
        push(10'h001, 32'h00209380);
        frm = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h00,
                8'h00, 8'h83, 8'h20, 8'h00, 8'h80, 8'h93, 8'h20, 8'h00, 8'h90};
        send_seq(frm);
        check_status("good_frame", 1'b1, 1'b0, 1'b0);
        check("good_frame_pending", 32'(exp_q.size()), 32'd0);
        check("write_count", 32'(we_cyc.size()), 32'd2);
        if (we_cyc.size() == 2)
            check("cycles_per_word", 32'(we_cyc[1] - we_cyc[0]), 32'd5);

        // Same frame, wrong checksum: words still written, error flagged.
        send(8'hA5);
        check_status("resync", 1'b0, 1'b0, 1'b1);
        push(10'h000, 32'h00208300);
        push(10'h001, 32'h00209380);
        frm = '{8'h00, 8'h00, 8'h02, 8'h00,
                8'h00, 8'h83, 8'h20, 8'h00, 8'h80, 8'h93, 8'h20, 8'h00, 8'h91};
        send_seq(frm);
        check_status("bad_csum", 1'b0, 1'b1, 1'b1);
        check("bad_csum_pending", 32'(exp_q.size()), 32'd0);

        // Address wrap: 0x3FF then 0x000; csum 44^00 = 0x44.
        push(10'h3FF, 32'h11223344);
        push(10'h000, 32'hAABBCCDD);
        frm = '{8'hA5, 8'hFF, 8'h03, 8'h02, 8'h00,
                8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44};
        send_seq(frm);
        check_status("wrap", 1'b1, 1'b0, 1'b0);
        check("wrap_pending", 32'(exp_q.size()), 32'd0);

        // Empty frame: no write, checksum 0 accepted.
        frm = '{8'hA5, 8'h1A, 8'h00, 8'h00, 8'h00, 8'h00};
        send_seq(frm);
        check_status("empty", 1'b1, 1'b0, 1'b0);

        // Reset asynchronously partway through the second word.
        push(10'h100, 32'h01020304);
        frm = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h00,
                8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07};
        send_seq(frm);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        check("async_rst_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Clean frame after reset with noise and in_valid gaps inside the word.
        frm = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h10, 8'h00, 8'h01, 8'h00};
        send_seq(frm);
        push(10'h010, 32'h12345678);
        send(8'h78);
        idle(3);
        send(8'h56);
        idle(2);
        send(8'h34);
        send(8'h12);
        send(8'h08);
        check_status("after_rst", 1'b1, 1'b0, 1'b0);
        check("after_rst_pending", 32'(exp_q.size()), 32'd0);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
